pipelined_wallace_multiplier: RTL and testbench

//  Parametrised, pipelined successor to the combinational 32x32 Wallace multiplier.

---
 rtl/pipelined_wallace_multiplier_if.sv | 42 ++++
 rtl/pipelined_wallace_multiplier.sv | 244 ++++++++++++++++++++++++
 tb/tb_pipelined_wallace_multiplier.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_wallace_multiplier_if.sv
// pipelined_wallace_multiplier_if
//   Handshake bundle between issue logic (master) and the pipelined multiplier (slave).
//   Parameters: WIDTH (operand width), TAG_W (opaque tag width).
//   Request side : in_valid, in_ready, in_a, in_b, in_signed, in_tag
//   Response side: out_valid, out_ready, out_product, out_tag
//   Optional     : out_ovf, present only when WALLACE_OVF_EN is defined.
interface pipelined_wallace_multiplier_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 in_signed;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_product;
   logic [TAG_W-1:0]     out_tag;
`ifdef WALLACE_OVF_EN
   logic                 out_ovf;
`endif

   // Issue side: drives operations, consumes results.
   modport master (
      output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
`ifdef WALLACE_OVF_EN
      input  out_ovf,
`endif
      input  in_ready, out_valid, out_product, out_tag
   );

   // Multiplier side: accepts operations, produces results.
   modport slave (
      input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
`ifdef WALLACE_OVF_EN
      output out_ovf,
`endif
      output in_ready, out_valid, out_product, out_tag
   );
endinterface

// File: rtl/pipelined_wallace_multiplier.sv
// pipelined_wallace_multiplier
//   Three-stage pipelined Wallace-tree multiplier with valid/ready handshake.
//   S1: partial products (Baugh-Wooley for signed, AND array for unsigned) plus the
//       first half of the 3:2 CSA levels. S2: remaining CSA levels down to two rows.
//   S3: 2*WIDTH-bit Kogge-Stone carry-lookahead add into the output register.
//   Ports: clk, rst_n (async active-low), bus (pipelined_wallace_multiplier_if.slave).
//   Optional feature: define WALLACE_OVF_EN to add bus.out_ovf, set when the product
//   does not fit in WIDTH bits for the operation's mode.
module pipelined_wallace_multiplier #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input logic                           clk,
   input logic                           rst_n,
   pipelined_wallace_multiplier_if.slave bus
);

   localparam int PW = 2 * WIDTH;
   // One row per multiplier bit plus one row for the Baugh-Wooley correction constant.
   localparam int NR = WIDTH + 1;

   function automatic int rows_after(input int n_in, input int levels);
      int n;
      n = n_in;
      for (int lv = 0; lv < 2 * NR; lv++) begin
         if (lv < levels && n > 2) n = 2 * (n / 3) + (n % 3);
      end
      return n;
   endfunction

   function automatic int count_levels(input int n_in);
      int n;
      int l;
      n = n_in;
      l = 0;
      for (int i = 0; i < 2 * NR; i++) begin
         if (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l++;
         end
      end
      return l;
   endfunction

   localparam int L_TOT = count_levels(NR);
   localparam int L_S1  = (L_TOT + 1) / 2;
   localparam int L_S2  = L_TOT - L_S1;
   localparam int R_S1  = rows_after(NR, L_S1);

   // Apply up to 'levels' Wallace levels: each full group of three rows becomes a
   // sum row and a left-shifted carry row, leftover rows pass straight through.
   function automatic logic [NR-1:0][PW-1:0] csa_reduce(
      input logic [NR-1:0][PW-1:0] rows,
      input int                    n_in,
      input int                    levels
   );
      logic [NR-1:0][PW-1:0] cur;
      logic [NR-1:0][PW-1:0] nxt;
      logic [PW-1:0]         a;
      logic [PW-1:0]         b;
      logic [PW-1:0]         c;
      int                    n;
      int                    k;
      cur = rows;
      n   = n_in;
      for (int lv = 0; lv < NR; lv++) begin
         if (lv < levels && n > 2) begin
            nxt = '0;
            k   = 0;
            for (int g = 0; g < NR / 3; g++) begin
               if (g < n / 3) begin
                  a          = cur[3*g];
                  b          = cur[3*g+1];
                  c          = cur[3*g+2];
                  nxt[k]     = a ^ b ^ c;
                  nxt[k+1]   = ((a & b) | (a & c) | (b & c)) << 1;
                  k          = k + 2;
               end
            end
            for (int r = 0; r < 2; r++) begin
               if (r < n % 3) begin
                  nxt[k] = cur[3*(n/3)+r];
                  k      = k + 1;
               end
            end
            cur = nxt;
            n   = k;
         end
      end
      return cur;
   endfunction

   logic                        adv;

   logic                        s1_valid_q, s1_valid_d;
   logic [R_S1-1:0][PW-1:0]     s1_rows_q, s1_rows_d;
   logic [TAG_W-1:0]            s1_tag_q, s1_tag_d;
   logic                        s2_valid_q, s2_valid_d;
   logic [PW-1:0]               s2_sum_q, s2_sum_d;
   logic [PW-1:0]               s2_carry_q, s2_carry_d;
   logic [TAG_W-1:0]            s2_tag_q, s2_tag_d;
   logic                        out_valid_q, out_valid_d;
   logic [PW-1:0]               out_product_q, out_product_d;
   logic [TAG_W-1:0]            out_tag_q, out_tag_d;
`ifdef WALLACE_OVF_EN
   logic                        s1_signed_q, s1_signed_d;
   logic                        s2_signed_q, s2_signed_d;
   logic                        out_ovf_q, out_ovf_d;
`endif

   logic [NR-1:0][PW-1:0]       pp_rows;
   logic [NR-1:0][PW-1:0]       s1_tree;
   logic [NR-1:0][PW-1:0]       s2_tree_in;
   logic [NR-1:0][PW-1:0]       s2_tree;
   logic [PW-1:0]               bit_p;
   logic [PW-1:0]               grp_p;
   logic [PW-1:0]               grp_g;
   logic [PW-1:0]               cla_sum;

   // Whole pipe moves together; a full output register blocks everything behind it.
   assign adv          = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = adv;

   // Partial products. Signed mode complements the terms where exactly one operand
   // bit is an MSB and adds 2^WIDTH + 2^(2*WIDTH-1) via the extra row.
   always_comb begin
      pp_rows = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pp_rows[i][i+j] = (bus.in_a[j] & bus.in_b[i]) ^
                              (bus.in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
         end
      end
      if (bus.in_signed) begin
         pp_rows[NR-1][WIDTH] = 1'b1;
         pp_rows[NR-1][PW-1]  = 1'b1;
      end
      s1_tree = csa_reduce(pp_rows, NR, L_S1);
   end

   // Second half of the tree works from the registered S1 rows.
   always_comb begin
      s2_tree_in             = '0;
      s2_tree_in[R_S1-1:0]   = s1_rows_q;
      s2_tree                = csa_reduce(s2_tree_in, R_S1, L_S2);
   end

   // Kogge-Stone prefix over the sum/carry rows; carry-in is zero so group
   // propagate reaching bit 0 never matters, and the carry-out is dropped.
   always_comb begin
      bit_p = s2_sum_q ^ s2_carry_q;
      grp_g = s2_sum_q & s2_carry_q;
      grp_p = bit_p;
      for (int d = 1; d < PW; d = d * 2) begin
         grp_g = grp_g | (grp_p & (grp_g << d));
         grp_p = grp_p & (grp_p << d);
      end
      cla_sum = bit_p ^ (grp_g << 1);
   end

   // Next-state for every pipeline register: hold on stall, shift on advance.
   always_comb begin
      s1_valid_d    = s1_valid_q;
      s1_rows_d     = s1_rows_q;
      s1_tag_d      = s1_tag_q;
      s2_valid_d    = s2_valid_q;
      s2_sum_d      = s2_sum_q;
      s2_carry_d    = s2_carry_q;
      s2_tag_d      = s2_tag_q;
      out_valid_d   = out_valid_q;
      out_product_d = out_product_q;
      out_tag_d     = out_tag_q;
`ifdef WALLACE_OVF_EN
      s1_signed_d   = s1_signed_q;
      s2_signed_d   = s2_signed_q;
      out_ovf_d     = out_ovf_q;
`endif
      if (adv) begin
         s1_valid_d    = bus.in_valid;
         s1_rows_d     = s1_tree[R_S1-1:0];
         s1_tag_d      = bus.in_tag;
         s2_valid_d    = s1_valid_q;
         s2_sum_d      = s2_tree[0];
         s2_carry_d    = s2_tree[1];
         s2_tag_d      = s1_tag_q;
         out_valid_d   = s2_valid_q;
         out_product_d = cla_sum;
         out_tag_d     = s2_tag_q;
`ifdef WALLACE_OVF_EN
         s1_signed_d   = bus.in_signed;
         s2_signed_d   = s1_signed_q;
         // Signed results fit only when the upper half and the WIDTH-1 sign bit agree.
         out_ovf_d     = s2_signed_q ?
                         ~((&cla_sum[PW-1:WIDTH-1]) | ~(|cla_sum[PW-1:WIDTH-1])) :
                         (|cla_sum[PW-1:WIDTH]);
`endif
      end
   end

   // Pipeline registers; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q    <= 1'b0;
         s1_rows_q     <= '0;
         s1_tag_q      <= '0;
         s2_valid_q    <= 1'b0;
         s2_sum_q      <= '0;
         s2_carry_q    <= '0;
         s2_tag_q      <= '0;
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
         out_tag_q     <= '0;
`ifdef WALLACE_OVF_EN
         s1_signed_q   <= 1'b0;
         s2_signed_q   <= 1'b0;
         out_ovf_q     <= 1'b0;
`endif
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_rows_q     <= s1_rows_d;
         s1_tag_q      <= s1_tag_d;
         s2_valid_q    <= s2_valid_d;
         s2_sum_q      <= s2_sum_d;
         s2_carry_q    <= s2_carry_d;
         s2_tag_q      <= s2_tag_d;
         out_valid_q   <= out_valid_d;
         out_product_q <= out_product_d;
         out_tag_q     <= out_tag_d;
`ifdef WALLACE_OVF_EN
         s1_signed_q   <= s1_signed_d;
         s2_signed_q   <= s2_signed_d;
         out_ovf_q     <= out_ovf_d;
`endif
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_product = out_product_q;
   assign bus.out_tag     = out_tag_q;
`ifdef WALLACE_OVF_EN
   assign bus.out_ovf     = out_ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// tb_pipelined_wallace_multiplier
//   Directed, table-driven bench for pipelined_wallace_multiplier (WIDTH=32, TAG_W=4).
//   Results are matched in order against a queue of expected records.
module tb_pipelined_wallace_multiplier;

   localparam int WIDTH = 32;
   localparam int TAG_W = 4;
   localparam int NVEC  = 14;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [3:0]  tag;
      logic [63:0] prod;
      logic        ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pipelined_wallace_multiplier_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   pipelined_wallace_multiplier #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   vec_t vecs [NVEC];
   vec_t expq [$];
   int   tests     = 0;
   int   failed    = 0;
   int   cycle     = 0;
   int   seen      = 0;
   int   first_out = -1;
   int   last_out  = -1;

   // One comparison; reports and counts a miss.
   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle after the rising edge, then observe at the falling edge:
   // a visible result with out_ready set is consumed, an accepted op is queued.
   task automatic apply_stimulus(input logic valid, input vec_t v, input logic oready);
      vec_t e;
      @(posedge clk);
      #1;
      bus.in_valid  = valid;
      bus.in_a      = v.a;
      bus.in_b      = v.b;
      bus.in_signed = v.sgn;
      bus.in_tag    = v.tag;
      bus.out_ready = oready;
      @(negedge clk);
      cycle++;
      if (bus.out_valid && bus.out_ready) begin
         seen++;
         if (first_out < 0) first_out = cycle;
         last_out = cycle;
         if (expq.size() == 0) begin
            tests++;
            failed++;
            $display("[TB] FAIL unexpected_result: got out_valid=1 product %h, expected no result",
                     bus.out_product);
         end else begin
            e = expq.pop_front();
            check_output("product", bus.out_product, e.prod);
            check_output("tag", 64'(bus.out_tag), 64'(e.tag));
`ifdef WALLACE_OVF_EN
            check_output("ovf", 64'(bus.out_ovf), 64'(e.ovf));
`endif
         end
      end
      if (bus.in_valid && bus.in_ready) expq.push_back(v);
   endtask

   // Idle with out_ready high until every expected result has been seen.
   task automatic drain(input string name);
      int n;
      n = 0;
      while (expq.size() != 0 && n < 20) begin
         apply_stimulus(1'b0, vecs[0], 1'b1);
         n++;
      end
      check_output({name, "_left_in_queue"}, 64'(expq.size()), 64'd0);
   endtask

   initial begin
      logic [63:0] hold_p;
      logic [3:0]  hold_t;
      int          acc_cycle;
      int          n;

      vecs[0]  = '{32'h00000000, 32'h00000000, 1'b0, 4'h0, 64'h0000000000000000, 1'b0};
      vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'h3, 64'hFFFFFFFE00000001, 1'b1};
      vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'h5, 64'h0000000000000001, 1'b0};
      vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 4'h6, 64'h4000000000000000, 1'b1};
      vecs[4]  = '{32'h80000000, 32'h00000001, 1'b1, 4'h7, 64'hFFFFFFFF80000000, 1'b0};
      vecs[5]  = '{32'h00010000, 32'h00010000, 1'b0, 4'h8, 64'h0000000100000000, 1'b1};
      vecs[6]  = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 4'h9, 64'h00000000FFFE0001, 1'b0};
      vecs[7]  = '{32'h12345678, 32'h00000010, 1'b0, 4'hA, 64'h0000000123456780, 1'b1};
      vecs[8]  = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 4'hB, 64'hFFFFFFFFFFFFFFFA, 1'b0};
      vecs[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 4'hC, 64'h3FFFFFFF00000001, 1'b1};
      vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 4'hD, 64'h0000000080000000, 1'b1};
      vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 4'hE, 64'h7FFFFFFF80000000, 1'b1};
      vecs[12] = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 4'hF, 64'hFFFFFFFFFFFFFFEB, 1'b0};
      vecs[13] = '{32'hFFFFFFFE, 32'h00000003, 1'b0, 4'h1, 64'h00000002FFFFFFFA, 1'b1};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_signed = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      // Reset state.
      #12;
      check_output("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check_output("reset_product", bus.out_product, 64'd0);
      check_output("reset_tag", 64'(bus.out_tag), 64'd0);
`ifdef WALLACE_OVF_EN
      check_output("reset_ovf", 64'(bus.out_ovf), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_output("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

      // Single op: result must appear exactly three cycles after acceptance.
      apply_stimulus(1'b1, vecs[1], 1'b1);
      acc_cycle = cycle;
      check_output("first_accept", 64'(expq.size()), 64'd1);
      n = 0;
      while (!bus.out_valid && n < 10) begin
         apply_stimulus(1'b0, vecs[0], 1'b1);
         n++;
      end
      check_output("latency", 64'(cycle - acc_cycle), 64'd3);
      drain("latency");

      // Back-to-back stream of every table entry with simultaneous accept and drain.
      seen      = 0;
      first_out = -1;
      for (int i = 0; i < NVEC; i++) begin
         apply_stimulus(1'b1, vecs[i], 1'b1);
         check_output("stream_in_ready", 64'(bus.in_ready), 64'd1);
      end
      drain("stream");
      check_output("stream_count", 64'(seen), 64'(NVEC));
      check_output("stream_consecutive", 64'(last_out - first_out), 64'(NVEC - 1));

      // Backpressure with a full pipe for five cycles, then release.
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, vecs[2+i], 1'b1);
      apply_stimulus(1'b1, vecs[6], 1'b0);
      hold_p = bus.out_product;
      hold_t = bus.out_tag;
      check_output("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check_output("stall_out_valid", 64'(bus.out_valid), 64'd1);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b1, vecs[6], 1'b0);
         check_output("stall_in_ready", 64'(bus.in_ready), 64'd0);
         check_output("stall_product_hold", bus.out_product, hold_p);
         check_output("stall_tag_hold", 64'(bus.out_tag), 64'(hold_t));
      end
      check_output("stall_queue_depth", 64'(expq.size()), 64'd3);
      drain("backpressure");

      // Asynchronous reset with three ops in flight.
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, vecs[7+i], 1'b1);
      apply_stimulus(1'b0, vecs[0], 1'b0);
      check_output("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
      check_output("async_reset_product", bus.out_product, 64'd0);
`ifdef WALLACE_OVF_EN
      check_output("async_reset_ovf", 64'(bus.out_ovf), 64'd0);
`endif
      expq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      for (int k = 0; k < 6; k++) apply_stimulus(1'b0, vecs[0], 1'b1);
      check_output("no_stale_results", 64'(seen), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Global watchdog so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
